// File: rtl/ysyx_22040759_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_mem_arbiter
//
// Purpose:
//   Shares the single data-RAM port of the multi-cycle core between the
//   instruction-fetch unit (read-only) and the load/store unit (read/write).
//   At most one requester is granted per cycle. The RAM control lines are
//   driven combinationally from the granted request. The response is
//   registered and returned exactly one cycle after the grant.
//
//   The LSU has fixed priority. A starvation counter tracks how many cycles
//   in a row the IFU has been requesting without a grant. Once the counter
//   reaches MAX_WAIT, the IFU is forced ahead of the LSU for one grant.
//
// Parameters:
//   MAX_WAIT : consecutive denied IFU cycles before forced IFU priority (1..15)
//   CNT_W    : starvation counter width, 2**CNT_W must exceed MAX_WAIT
//
// Ports:
//   i_clk, i_rst        : clock and synchronous active-high reset
//   i_ifu_req_valid     : IFU fetch request
//   o_ifu_req_ready     : IFU grant (handshake completes on valid & ready)
//   i_ifu_addr          : 4-byte aligned fetch address
//   o_ifu_rsp_valid     : one-cycle pulse, fetched instruction valid
//   o_ifu_rsp_inst      : fetched 32-bit instruction (held until next fetch)
//   i_lsu_req_valid     : LSU request
//   o_lsu_req_ready     : LSU grant
//   i_lsu_we            : 1 = store, 0 = load
//   i_lsu_func3         : RISC-V funct3 of the access, forwarded to the RAM
//   i_lsu_addr          : load/store address
//   i_lsu_wdata         : store data
//   o_lsu_rsp_valid     : one-cycle pulse, load data or store acknowledge
//   o_lsu_rsp_data      : load data, zero for a store acknowledge
//   o_mem_ren/o_mem_wen : RAM read/write enables
//   o_mem_func3         : RAM access size/type
//   o_mem_raddr         : RAM read address
//   o_mem_waddr         : RAM write address
//   o_mem_wdata         : RAM write data
//   i_mem_rdata         : RAM combinational read data
// ----------------------------------------------------------------------------
module ysyx_22040759_mem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_ifu_req_valid,
    output logic        o_ifu_req_ready,
    input  logic [63:0] i_ifu_addr,
    output logic        o_ifu_rsp_valid,
    output logic [31:0] o_ifu_rsp_inst,

    input  logic        i_lsu_req_valid,
    output logic        o_lsu_req_ready,
    input  logic        i_lsu_we,
    input  logic [2:0]  i_lsu_func3,
    input  logic [63:0] i_lsu_addr,
    input  logic [63:0] i_lsu_wdata,
    output logic        o_lsu_rsp_valid,
    output logic [63:0] o_lsu_rsp_data,

    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [2:0]  o_mem_func3,
    output logic [63:0] o_mem_raddr,
    output logic [63:0] o_mem_waddr,
    output logic [63:0] o_mem_wdata,
    input  logic [63:0] i_mem_rdata
);

    // Fetches are always full 64-bit reads; the word is picked afterwards.
    localparam logic [2:0]       FUNC3_FETCH = 3'b011;
    localparam logic [CNT_W-1:0] WAIT_LIMIT  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ifu_rsp_valid;
    logic [31:0]      r_ifu_rsp_inst;
    logic             r_lsu_rsp_valid;
    logic [63:0]      r_lsu_rsp_data;

    logic             w_force_ifu;
    logic             w_ifu_grant;
    logic             w_lsu_grant;
    logic [31:0]      w_fetch_word;

    assign w_force_ifu = (r_cnt == WAIT_LIMIT);

    // Address bit 2 selects which half of the 64-bit RAM word holds the
    // instruction.
    assign w_fetch_word = i_ifu_addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0];

    // Grant selection. The LSU wins, unless the IFU has waited long enough
    // and is still requesting. Reset suppresses every grant, so nothing
    // reaches the RAM or the response registers during a reset cycle.
    always_comb begin
        w_ifu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        if (!i_rst) begin
            if (i_lsu_req_valid && !(w_force_ifu && i_ifu_req_valid)) begin
                w_lsu_grant = 1'b1;
            end else if (i_ifu_req_valid) begin
                w_ifu_grant = 1'b1;
            end
        end
    end

    assign o_ifu_req_ready = w_ifu_grant;
    assign o_lsu_req_ready = w_lsu_grant;

    // RAM port mux. When idle, func3 rests at the fetch encoding. During
    // reset, every RAM output, func3 included, is forced to zero.
    always_comb begin
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_func3 = FUNC3_FETCH;
        o_mem_raddr = 64'd0;
        o_mem_waddr = 64'd0;
        o_mem_wdata = 64'd0;
        if (i_rst) begin
            o_mem_func3 = 3'b000;
        end else if (w_lsu_grant) begin
            o_mem_func3 = i_lsu_func3;
            if (i_lsu_we) begin
                o_mem_wen   = 1'b1;
                o_mem_waddr = i_lsu_addr;
                o_mem_wdata = i_lsu_wdata;
            end else begin
                o_mem_ren   = 1'b1;
                o_mem_raddr = i_lsu_addr;
            end
        end else if (w_ifu_grant) begin
            o_mem_ren   = 1'b1;
            o_mem_raddr = i_ifu_addr;
        end
    end

    // Starvation counter. It counts consecutive cycles in which the IFU
    // asks but is not served, and it saturates at the limit. It clears as
    // soon as the IFU is served or stops asking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_ifu_req_valid && !w_ifu_grant) begin
            if (r_cnt < WAIT_LIMIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // IFU response. The valid bit is a one-cycle pulse that follows the
    // grant. The instruction register keeps its value until the next fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_inst  <= 32'd0;
        end else begin
            r_ifu_rsp_valid <= w_ifu_grant;
            if (w_ifu_grant) begin
                r_ifu_rsp_inst <= w_fetch_word;
            end
        end
    end

    // LSU response. A load captures the RAM data. A store is acknowledged
    // with zero data, so consumers never see stale load data on a store.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_data  <= 64'd0;
        end else begin
            r_lsu_rsp_valid <= w_lsu_grant;
            if (w_lsu_grant) begin
                r_lsu_rsp_data <= i_lsu_we ? 64'd0 : i_mem_rdata;
            end
        end
    end

    assign o_ifu_rsp_valid = r_ifu_rsp_valid;
    assign o_ifu_rsp_inst  = r_ifu_rsp_inst;
    assign o_lsu_rsp_valid = r_lsu_rsp_valid;
    assign o_lsu_rsp_data  = r_lsu_rsp_data;

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040759_mem_arbiter
//
// Purpose:
//   Self-checking bench for the IFU/LSU data-RAM arbiter. Directed vectors
//   come from a table of {inputs, expected outputs}. Random traffic follows
//   and is compared against a reference model that keeps the arbitration
//   rules as plain integer bookkeeping.
//
// Timing:
//   Inputs change on the falling edge. Outputs are sampled 1 ns later, away
//   from the rising edge. Each check therefore sees the combinational grant
//   for the current inputs together with the registered responses produced
//   by the previous cycle.
// ----------------------------------------------------------------------------
module tb_ysyx_22040759_mem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic        rst;
        logic        ifuValid;
        logic [63:0] ifuAddr;
        logic        lsuValid;
        logic        lsuWe;
        logic [2:0]  lsuFunc3;
        logic [63:0] lsuAddr;
        logic [63:0] lsuWdata;
        logic [63:0] memRdata;
    } ins_t;

    typedef struct packed {
        logic        ifuReady;
        logic        lsuReady;
        logic        memRen;
        logic        memWen;
        logic [2:0]  memFunc3;
        logic [63:0] memRaddr;
        logic [63:0] memWaddr;
        logic [63:0] memWdata;
        logic        ifuRspValid;
        logic [31:0] ifuRspInst;
        logic        lsuRspValid;
        logic [63:0] lsuRspData;
        logic [3:0]  cnt;
    } outs_t;

    typedef struct packed {
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifuReqValid, ifuReqReady, ifuRspValid;
    logic [63:0] ifuAddr;
    logic [31:0] ifuRspInst;
    logic        lsuReqValid, lsuReqReady, lsuWe, lsuRspValid;
    logic [2:0]  lsuFunc3;
    logic [63:0] lsuAddr, lsuWdata, lsuRspData;
    logic        memRen, memWen;
    logic [2:0]  memFunc3;
    logic [63:0] memRaddr, memWaddr, memWdata, memRdata;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the consecutive denied IFU cycles and the
    // response registers as the requesters would see them.
    int          mWaited;
    logic        mIfuRspValid;
    logic [31:0] mIfuRspInst;
    logic        mLsuRspValid;
    logic [63:0] mLsuRspData;

    vec_t vecs [17];

    always #5 clk = ~clk;

    ysyx_22040759_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ifu_req_valid (ifuReqValid),
        .o_ifu_req_ready (ifuReqReady),
        .i_ifu_addr      (ifuAddr),
        .o_ifu_rsp_valid (ifuRspValid),
        .o_ifu_rsp_inst  (ifuRspInst),
        .i_lsu_req_valid (lsuReqValid),
        .o_lsu_req_ready (lsuReqReady),
        .i_lsu_we        (lsuWe),
        .i_lsu_func3     (lsuFunc3),
        .i_lsu_addr      (lsuAddr),
        .i_lsu_wdata     (lsuWdata),
        .o_lsu_rsp_valid (lsuRspValid),
        .o_lsu_rsp_data  (lsuRspData),
        .o_mem_ren       (memRen),
        .o_mem_wen       (memWen),
        .o_mem_func3     (memFunc3),
        .o_mem_raddr     (memRaddr),
        .o_mem_waddr     (memWaddr),
        .o_mem_wdata     (memWdata),
        .i_mem_rdata     (memRdata)
    );

    function automatic ins_t mkIns(logic r, logic iv, logic [63:0] ia, logic lv,
                                   logic we, logic [2:0] f3, logic [63:0] la,
                                   logic [63:0] wd, logic [63:0] rd);
        ins_t s;
        s.rst = r; s.ifuValid = iv; s.ifuAddr = ia; s.lsuValid = lv;
        s.lsuWe = we; s.lsuFunc3 = f3; s.lsuAddr = la; s.lsuWdata = wd;
        s.memRdata = rd;
        return s;
    endfunction

    function automatic outs_t mkOuts(logic ir, logic lr, logic ren, logic wen,
                                     logic [2:0] f3, logic [63:0] ra, logic [63:0] wa,
                                     logic [63:0] wd, logic iv, logic [31:0] inst,
                                     logic lv, logic [63:0] ld, logic [3:0] c);
        outs_t o;
        o.ifuReady = ir; o.lsuReady = lr; o.memRen = ren; o.memWen = wen;
        o.memFunc3 = f3; o.memRaddr = ra; o.memWaddr = wa; o.memWdata = wd;
        o.ifuRspValid = iv; o.ifuRspInst = inst; o.lsuRspValid = lv;
        o.lsuRspData = ld; o.cnt = c;
        return o;
    endfunction

    // Drive one cycle of inputs on the falling edge, then wait to sample.
    task automatic applyStimulus(input ins_t s);
        @(negedge clk);
        rst         = s.rst;
        ifuReqValid = s.ifuValid;
        ifuAddr     = s.ifuAddr;
        lsuReqValid = s.lsuValid;
        lsuWe       = s.lsuWe;
        lsuFunc3    = s.lsuFunc3;
        lsuAddr     = s.lsuAddr;
        lsuWdata    = s.lsuWdata;
        memRdata    = s.memRdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input outs_t e);
        outs_t a;
        a = mkOuts(ifuReqReady, lsuReqReady, memRen, memWen, memFunc3, memRaddr,
                   memWaddr, memWdata, ifuRspValid, ifuRspInst, lsuRspValid,
                   lsuRspData, dut.r_cnt);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got rdy=%b%b ren=%b wen=%b f3=%h ra=%h wa=%h wd=%h irv=%b inst=%h lrv=%b ld=%h cnt=%0d | required rdy=%b%b ren=%b wen=%b f3=%h ra=%h wa=%h wd=%h irv=%b inst=%h lrv=%b ld=%h cnt=%0d",
                     tag, a.ifuReady, a.lsuReady, a.memRen, a.memWen, a.memFunc3,
                     a.memRaddr, a.memWaddr, a.memWdata, a.ifuRspValid, a.ifuRspInst,
                     a.lsuRspValid, a.lsuRspData, a.cnt,
                     e.ifuReady, e.lsuReady, e.memRen, e.memWen, e.memFunc3,
                     e.memRaddr, e.memWaddr, e.memWdata, e.ifuRspValid, e.ifuRspInst,
                     e.lsuRspValid, e.lsuRspData, e.cnt);
        end
    endtask

    // Reference model. It predicts the outputs for this cycle from the
    // arbitration rules, then advances its state past the coming clock edge.
    task automatic modelStep(input ins_t s, output outs_t e);
        logic ifuWins, lsuWins;
        ifuWins = 1'b0;
        lsuWins = 1'b0;
        e = '0;
        e.ifuRspValid = mIfuRspValid;
        e.ifuRspInst  = mIfuRspInst;
        e.lsuRspValid = mLsuRspValid;
        e.lsuRspData  = mLsuRspData;
        e.cnt         = 4'(mWaited);
        if (!s.rst) begin
            e.memFunc3 = 3'b011;
            if (s.lsuValid && !(mWaited == MAX_WAIT && s.ifuValid)) lsuWins = 1'b1;
            else if (s.ifuValid) ifuWins = 1'b1;
            if (lsuWins) begin
                e.lsuReady = 1'b1;
                e.memFunc3 = s.lsuFunc3;
                if (s.lsuWe) begin
                    e.memWen   = 1'b1;
                    e.memWaddr = s.lsuAddr;
                    e.memWdata = s.lsuWdata;
                end else begin
                    e.memRen   = 1'b1;
                    e.memRaddr = s.lsuAddr;
                end
            end else if (ifuWins) begin
                e.ifuReady = 1'b1;
                e.memRen   = 1'b1;
                e.memRaddr = s.ifuAddr;
            end
        end
        if (s.rst) begin
            mWaited = 0; mIfuRspValid = 0; mIfuRspInst = 0;
            mLsuRspValid = 0; mLsuRspData = 0;
        end else begin
            mIfuRspValid = ifuWins;
            if (ifuWins) mIfuRspInst = s.ifuAddr[2] ? s.memRdata[63:32] : s.memRdata[31:0];
            mLsuRspValid = lsuWins;
            if (lsuWins) mLsuRspData = s.lsuWe ? 64'd0 : s.memRdata;
            if (s.ifuValid && !ifuWins) mWaited = (mWaited < MAX_WAIT) ? mWaited + 1 : MAX_WAIT;
            else mWaited = 0;
        end
    endtask

    initial begin
        logic [63:0] rd1, rd2, rd3, rd4;
        outs_t e;
        ins_t  s;
        rd1 = 64'h1111_2222_3333_4444;
        rd2 = 64'hAAAA_BBBB_CCCC_DDDD;
        rd3 = 64'h0123_4567_89AB_CDEF;
        rd4 = 64'hFEDC_BA98_7654_3210;

        // Directed vectors. The response fields and cnt show the state left
        // by the previous row.
        vecs[0]  = '{mkIns(0,0,0,0,0,0,0,0,0),
                     mkOuts(0,0,0,0,3,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{mkIns(0,1,64'h8000_0004,0,0,0,0,0,rd1),
                     mkOuts(1,0,1,0,3,64'h8000_0004,0,0,0,0,0,0,0)};
        vecs[2]  = '{mkIns(0,1,64'h8000_0000,0,0,0,0,0,rd1),
                     mkOuts(1,0,1,0,3,64'h8000_0000,0,0,1,32'h1111_2222,0,0,0)};
        vecs[3]  = '{mkIns(0,0,0,1,1,3'b010,64'h8000_0100,64'hDEAD_BEEF,rd1),
                     mkOuts(0,1,0,1,3'b010,0,64'h8000_0100,64'hDEAD_BEEF,1,32'h3333_4444,0,0,0)};
        vecs[4]  = '{mkIns(0,0,0,0,0,0,0,0,rd1),
                     mkOuts(0,0,0,0,3,0,0,0,0,32'h3333_4444,1,0,0)};
        vecs[5]  = '{mkIns(0,1,64'h8000_0008,1,0,3,64'h8000_0200,0,rd2),
                     mkOuts(0,1,1,0,3,64'h8000_0200,0,0,0,32'h3333_4444,0,0,0)};
        vecs[6]  = '{mkIns(0,1,64'h8000_0008,1,0,3,64'h8000_0200,0,rd2),
                     mkOuts(0,1,1,0,3,64'h8000_0200,0,0,0,32'h3333_4444,1,rd2,1)};
        vecs[7]  = '{mkIns(0,1,64'h8000_0008,1,0,3,64'h8000_0200,0,rd2),
                     mkOuts(0,1,1,0,3,64'h8000_0200,0,0,0,32'h3333_4444,1,rd2,2)};
        vecs[8]  = '{mkIns(0,1,64'h8000_0008,1,0,3,64'h8000_0200,0,rd2),
                     mkOuts(0,1,1,0,3,64'h8000_0200,0,0,0,32'h3333_4444,1,rd2,3)};
        vecs[9]  = '{mkIns(0,1,64'h8000_0008,1,0,3,64'h8000_0200,0,rd2),
                     mkOuts(1,0,1,0,3,64'h8000_0008,0,0,0,32'h3333_4444,1,rd2,4)};
        vecs[10] = '{mkIns(0,1,64'h8000_0008,1,0,3,64'h8000_0200,0,rd2),
                     mkOuts(0,1,1,0,3,64'h8000_0200,0,0,1,32'hCCCC_DDDD,0,rd2,0)};
        vecs[11] = '{mkIns(0,0,0,1,0,3,64'h8000_0300,0,rd3),
                     mkOuts(0,1,1,0,3,64'h8000_0300,0,0,0,32'hCCCC_DDDD,1,rd2,1)};
        vecs[12] = '{mkIns(0,1,64'h8000_0004,0,0,0,0,0,rd4),
                     mkOuts(1,0,1,0,3,64'h8000_0004,0,0,0,32'hCCCC_DDDD,1,rd3,0)};
        vecs[13] = '{mkIns(0,0,0,0,0,0,0,0,0),
                     mkOuts(0,0,0,0,3,0,0,0,1,32'hFEDC_BA98,0,rd3,0)};
        vecs[14] = '{mkIns(0,1,64'h8000_0010,1,1,3,64'h8000_0400,64'h55,0),
                     mkOuts(0,1,0,1,3,0,64'h8000_0400,64'h55,0,32'hFEDC_BA98,0,rd3,0)};
        vecs[15] = '{mkIns(1,1,64'h8000_0010,1,1,3,64'h8000_0500,64'h66,0),
                     mkOuts(0,0,0,0,0,0,0,0,0,32'hFEDC_BA98,1,0,1)};
        vecs[16] = '{mkIns(0,0,0,0,0,0,0,0,0),
                     mkOuts(0,0,0,0,3,0,0,0,0,0,0,0,0)};

        $display("[TB] reset");
        applyStimulus(mkIns(1,0,0,0,0,0,0,0,0));
        applyStimulus(mkIns(1,0,0,0,0,0,0,0,0));
        checkOutput("reset_hold", mkOuts(0,0,0,0,0,0,0,0,0,0,0,0,0));

        $display("[TB] directed vectors");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        $display("[TB] random traffic");
        mWaited = 0; mIfuRspValid = 0; mIfuRspInst = 0;
        mLsuRspValid = 0; mLsuRspData = 0;
        for (int i = 0; i < 600; i++) begin
            s.rst      = ($urandom_range(39) == 0);
            s.ifuValid = ($urandom_range(3) != 0);
            s.ifuAddr  = {$urandom, $urandom} & ~64'h3;
            s.lsuValid = ($urandom_range(3) != 0);
            s.lsuWe    = $urandom_range(1) == 1;
            s.lsuFunc3 = 3'($urandom_range(7));
            s.lsuAddr  = {$urandom, $urandom};
            s.lsuWdata = {$urandom, $urandom};
            s.memRdata = {$urandom, $urandom};
            applyStimulus(s);
            modelStep(s, e);
            checkOutput($sformatf("rand%0d", i), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
